chicken_turn_controller: RTL and testbench
==========================================

Name: chicken_turn_controller

Overview:
- Downstream consumer of the board-order generator. Latches the 96-bit edge tile order (24 x 4-bit tile IDs) and the 48-bit center card order (12 x 4-bit card IDs) on `load`.
- Runs the Chicken Cha-Cha-Cha turn loop: a player picks a face-down center card. The block compares that card to the edge tile ahead of the current player's chicken, then advances the chicken, ends the turn, or declares a winner.
- Sits between the generator and the input/display logic.

Parameters:
- EDGE_N, 24, number of edge tiles (positions 0..23, wrap-around)
- CENTER_N, 12, number of center cards
- TILE_W, 4, bits per tile/card ID
- SHOW_CYCLES, 4, cycles a mismatched card stays revealed before the turn passes (must be >= 1)
- WIN_STEPS, 24, total accepted advances a player needs to win

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load  in  1  one-cycle pulse: latch orders, start a new game
- edge_order  in  96  edge tile IDs; position p = bits [p*4 +: 4]
- center_order  in  48  center card IDs; card i = bits [i*4 +: 4]
- pick_valid  in  1  player presents a card pick
- pick_idx  in  4  center card index
- pick_ready  out  1  block can accept a pick
- pick_err  out  1  one-cycle pulse: accepted pick was illegal
- result_valid  out  1  one-cycle pulse: pick evaluated
- result_match  out  1  qualifies result_valid: 1 = card matched target
- cur_player  out  1  player whose turn it is
- pos_p0, pos_p1  out  5 each  chicken positions, 0..23
- reveal_mask  out  12  center cards currently face-up
- game_over  out  1  high in DONE
- winner  out  1  winning player, valid while game_over

Behaviour:
- Reset: all outputs 0, except pos_p1 = 12. State IDLE. Latched orders cleared to 0. Step counters cleared.
- States: IDLE, READY, CHECK, SHOW, DONE.
- IDLE:
  - pick_ready = 0.
  - `load` -> latch both orders, pos_p0 = 0, pos_p1 = 12, steps = 0, cur_player = 0, mask = 0 -> READY.
- `load` in any state other than IDLE restarts the game identically (re-latch, reset positions) and wins over any pick in the same cycle.
- READY:
  - pick_ready = 1.
  - Handshake is pick_valid & pick_ready.
  - Illegal pick (pick_idx >= CENTER_N, or reveal_mask[pick_idx] already set): pick_err pulses next cycle, no other state change, stays READY.
  - Legal pick: set reveal_mask[pick_idx], register the index -> CHECK.
- CHECK (1 cycle, pick_ready = 0):
  - target position t = (pos_cur + 1) mod 24.
  - Compare center card at the registered index with edge tile at t.
  - result_valid pulses in this cycle; result_match = equality.
  - Match: pos_cur <= t; steps_cur += 1.
    - If steps_cur reaches WIN_STEPS -> DONE with winner = cur_player.
    - Else if reveal_mask is all ones -> clear mask, toggle cur_player -> READY.
    - Else -> READY, same player continues.
  - Mismatch -> SHOW.
- SHOW:
  - pick_ready = 0; mask held for exactly SHOW_CYCLES cycles.
  - Then clear mask, toggle cur_player -> READY.
- Turn boundary: each new turn starts with mask = 0.
- DONE: game_over = 1, pick_ready = 0, positions frozen. Leaves only on `load` or rst.
- Position arithmetic: modulo EDGE_N, 23 + 1 -> 0. Step counters are 5-bit and saturate at WIN_STEPS.
- rst mid-SHOW or mid-CHECK: immediate return to reset values; no result pulse.
- A pick_valid held through non-READY states is ignored (no handshake).

Optional Feature:
- CHICKEN_JUMP_EN defined:
  - If (pos_cur + 1) mod 24 equals the opponent's position, the target becomes (pos_cur + 2) mod 24.
  - On a match the chicken lands on that target and steps_cur += 2 (still saturating).
- CHICKEN_JUMP_EN undefined: target is always pos_cur + 1, chickens may share a position, and each match adds 1 step.

Test Plan:
- Reset state: assert rst for 3 cycles -> pick_ready = 0, pos_p0 = 0, pos_p1 = 12, mask = 0, game_over = 0.
- Matched pick: load edge nibble p = p mod 12 and center card i = i, then pick 1 -> result_valid, match = 1, pos_p0 = 1, cur_player = 0, mask = 0x002.
- Mismatched pick: then pick 5 -> match = 0, mask = 0x022 for 4 cycles, then mask = 0, cur_player = 1, pos_p0 stays 1.
- Illegal picks: pick 12 -> pick_err, no state change. Pick an already revealed index -> pick_err.
- Jump and wrap, run twice (with and without CHICKEN_JUMP_EN): drive pos_p0 to 11 with pos_p1 = 12, then pick 1.
  - With CHICKEN_JUMP_EN: pos_p0 = 13, steps +2.
  - Without: pick 0 matches, pos_p0 = 12.
  - In a separate sequence, an advance from pos 23 wraps to 0.
- Win and mid-game reset: with WIN_STEPS = 3, three consecutive matches -> game_over = 1, winner = 0, pick_ready = 0. Then load -> READY with fresh positions. Separately, rst during SHOW -> reset values immediately.

Source files
------------

// File: rtl/chicken_turn_controller.sv
// Chicken Cha-Cha-Cha turn controller: latches the board orders on load and runs the
// pick / compare / advance loop. Define CHICKEN_JUMP_EN to let a chicken leap an opponent directly ahead.
module chicken_turn_controller #(
  parameter int EDGE_N      = 24,
  parameter int CENTER_N    = 12,
  parameter int TILE_W      = 4,
  parameter int SHOW_CYCLES = 4,
  parameter int WIN_STEPS   = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [EDGE_N*TILE_W-1:0]   edge_order,
  input  logic [CENTER_N*TILE_W-1:0] center_order,
  input  logic                       pick_valid,
  input  logic [3:0]                 pick_idx,
  output logic                       pick_ready,
  output logic                       pick_err,
  output logic                       result_valid,
  output logic                       result_match,
  output logic                       cur_player,
  output logic [4:0]                 pos_p0,
  output logic [4:0]                 pos_p1,
  output logic [CENTER_N-1:0]        reveal_mask,
  output logic                       game_over,
  output logic                       winner
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [4:0] P1_HOME = 5'(EDGE_N / 2);
  localparam logic [CENTER_N-1:0] MASK_ZERO = {CENTER_N{1'b0}};
  localparam logic [CENTER_N-1:0] MASK_ONE  = {{(CENTER_N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_READY, S_CHECK, S_SHOW, S_DONE} state_t;

  state_t                     state_r, state_s;
  logic [EDGE_N*TILE_W-1:0]   edge_r, edge_s;
  logic [CENTER_N*TILE_W-1:0] center_r, center_s;
  logic [4:0]                 pos0_r, pos0_s, pos1_r, pos1_s;
  logic [4:0]                 steps0_r, steps0_s, steps1_r, steps1_s;
  logic                       cur_r, cur_s;
  logic [CENTER_N-1:0]        mask_r, mask_s;
  logic [CNT_W-1:0]           cnt_r, cnt_s;
  logic                       ready_r, ready_s, err_r, err_s, rv_r, rv_s, match_r, match_s;
  logic                       over_r, over_s, winner_r, winner_s;

  logic [4:0]          pos_cur_s, steps_cur_s, target_s;
  logic [1:0]          adv_s;
  logic [5:0]          step_sum_s;
  logic                win_s, legal_s;
  logic [CENTER_N-1:0] sel_mask_s;
  logic [TILE_W-1:0]   card_s, tile_s;
`ifdef CHICKEN_JUMP_EN
  logic [4:0]          pos_opp_s;
`endif

  function automatic logic [4:0] pos_inc(input logic [4:0] p, input logic [1:0] n);
    logic [5:0] sum;
    sum = {1'b0, p} + {4'b0000, n};
    if (sum >= 6'(EDGE_N)) begin
      pos_inc = 5'(sum - 6'(EDGE_N));
    end else begin
      pos_inc = sum[4:0];
    end
  endfunction

  // Next-state, board bookkeeping and next output values
  always_comb begin
    state_s = state_r;  edge_s = edge_r;    center_s = center_r;
    pos0_s = pos0_r;    pos1_s = pos1_r;    steps0_s = steps0_r;  steps1_s = steps1_r;
    cur_s = cur_r;      mask_s = mask_r;    cnt_s = cnt_r;        winner_s = winner_r;
    err_s = 1'b0;       rv_s = 1'b0;        match_s = 1'b0;

    pos_cur_s   = cur_r ? pos1_r : pos0_r;
    steps_cur_s = cur_r ? steps1_r : steps0_r;
`ifdef CHICKEN_JUMP_EN
    pos_opp_s = cur_r ? pos0_r : pos1_r;
    if (pos_inc(pos_cur_s, 2'd1) == pos_opp_s) begin
      adv_s = 2'd2;
    end else begin
      adv_s = 2'd1;
    end
`else
    adv_s = 2'd1;
`endif
    target_s   = pos_inc(pos_cur_s, adv_s);
    step_sum_s = {1'b0, steps_cur_s} + {4'b0000, adv_s};
    win_s      = (step_sum_s >= 6'(WIN_STEPS));
    sel_mask_s = MASK_ONE << pick_idx;
    legal_s    = (pick_idx < 4'(CENTER_N)) && ((mask_r & sel_mask_s) == MASK_ZERO);
    card_s     = center_r[pick_idx*TILE_W +: TILE_W];
    tile_s     = edge_r[target_s*TILE_W +: TILE_W];

    if (load) begin
      edge_s = edge_order;  center_s = center_order;
      pos0_s = 5'd0;        pos1_s = P1_HOME;
      steps0_s = 5'd0;      steps1_s = 5'd0;
      cur_s = 1'b0;         mask_s = MASK_ZERO;  winner_s = 1'b0;
      state_s = S_READY;
    end else begin
      case (state_r)
        S_IDLE: state_s = S_IDLE;
        S_READY: begin
          if (pick_valid && ready_r) begin
            if (legal_s) begin
              // Match is decided at the handshake so result_match is a clean register in CHECK
              mask_s  = mask_r | sel_mask_s;
              rv_s    = 1'b1;
              match_s = (card_s == tile_s);
              state_s = S_CHECK;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            state_s = S_READY;
          end
        end
        S_CHECK: begin
          if (match_r) begin
            if (cur_r) begin
              pos1_s   = target_s;
              steps1_s = win_s ? 5'(WIN_STEPS) : step_sum_s[4:0];
            end else begin
              pos0_s   = target_s;
              steps0_s = win_s ? 5'(WIN_STEPS) : step_sum_s[4:0];
            end
            if (win_s) begin
              winner_s = cur_r;
              state_s  = S_DONE;
            end else if (&mask_r) begin
              mask_s  = MASK_ZERO;
              cur_s   = ~cur_r;
              state_s = S_READY;
            end else begin
              state_s = S_READY;
            end
          end else begin
            cnt_s   = CNT_W'(SHOW_CYCLES - 1);
            state_s = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            mask_s  = MASK_ZERO;
            cur_s   = ~cur_r;
            state_s = S_READY;
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        S_DONE:  state_s = S_DONE;
        default: state_s = S_IDLE;
      endcase
    end

    ready_s = (state_s == S_READY);
    over_s  = (state_s == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;   edge_r <= '0;       center_r <= '0;
      pos0_r <= 5'd0;      pos1_r <= P1_HOME;  steps0_r <= 5'd0;  steps1_r <= 5'd0;
      cur_r <= 1'b0;       mask_r <= MASK_ZERO; cnt_r <= {CNT_W{1'b0}};
      ready_r <= 1'b0;     err_r <= 1'b0;      rv_r <= 1'b0;      match_r <= 1'b0;
      over_r <= 1'b0;      winner_r <= 1'b0;
    end else begin
      state_r <= state_s;  edge_r <= edge_s;   center_r <= center_s;
      pos0_r <= pos0_s;    pos1_r <= pos1_s;   steps0_r <= steps0_s;  steps1_r <= steps1_s;
      cur_r <= cur_s;      mask_r <= mask_s;   cnt_r <= cnt_s;
      ready_r <= ready_s;  err_r <= err_s;     rv_r <= rv_s;      match_r <= match_s;
      over_r <= over_s;    winner_r <= winner_s;
    end
  end

  assign pick_ready   = ready_r;
  assign pick_err     = err_r;
  assign result_valid = rv_r;
  assign result_match = match_r;
  assign cur_player   = cur_r;
  assign pos_p0       = pos0_r;
  assign pos_p1       = pos1_r;
  assign reveal_mask  = mask_r;
  assign game_over    = over_r;
  assign winner       = winner_r;

endmodule

// File: tb/tb_chicken_turn_controller.sv
// Scoreboard bench for chicken_turn_controller: a game-level reference model predicts each pick's
// response (queued, checked by a monitor) plus turn latency and board state before every pick.
module tb_chicken_turn_controller;
  localparam int SHOW = 4;
  localparam int WIN  = 24;

  logic        clk = 1'b0, rst = 1'b0, load = 1'b0, pick_valid = 1'b0;
  logic [95:0] edge_order = '0;
  logic [47:0] center_order = '0;
  logic [3:0]  pick_idx = 4'd0;
  logic        pick_ready, pick_err, result_valid, result_match, cur_player, game_over, winner;
  logic [4:0]  pos_p0, pos_p1;
  logic [11:0] reveal_mask;

  chicken_turn_controller #(.EDGE_N(24), .CENTER_N(12), .TILE_W(4), .SHOW_CYCLES(SHOW),
                            .WIN_STEPS(WIN)) dut (
    .clk(clk), .rst(rst), .load(load), .edge_order(edge_order), .center_order(center_order),
    .pick_valid(pick_valid), .pick_idx(pick_idx), .pick_ready(pick_ready), .pick_err(pick_err),
    .result_valid(result_valid), .result_match(result_match), .cur_player(cur_player),
    .pos_p0(pos_p0), .pos_p1(pos_p1), .reveal_mask(reveal_mask), .game_over(game_over),
    .winner(winner));

  always #5 clk = ~clk;

  typedef struct packed { logic is_err; logic match; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  // Reference game state
  int m_edge[24], m_card[12], m_pos[2], m_steps[2];
  int m_cur, m_winner;
  bit m_rev[12];
  bit m_active, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] m = 0;
    for (int i = 0; i < 12; i++) if (m_rev[i]) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int m_target();
    int t = (m_pos[m_cur] + 1) % 24;
`ifdef CHICKEN_JUMP_EN
    if (t == m_pos[1 - m_cur]) t = (m_pos[m_cur] + 2) % 24;
`endif
    return t;
  endfunction

  function automatic void m_restart(input bit active);
    m_pos[0] = 0; m_pos[1] = 12; m_steps[0] = 0; m_steps[1] = 0;
    m_cur = 0; m_winner = 0; m_done = 0; m_active = active;
    for (int i = 0; i < 12; i++) m_rev[i] = 0;
  endfunction

  // Applies one pick to the model; low = cycles pick_ready stays low afterwards
  task automatic model_pick(input int idx, output bit is_err, output bit match, output int low);
    int t, adv;
    bit all;
    match = 0;
    if (idx >= 12 || m_rev[idx]) begin
      is_err = 1; low = 0;
      return;
    end
    is_err = 0;
    m_rev[idx] = 1;
    t = m_target();
    match = (m_card[idx] == m_edge[t]);
    if (match) begin
      adv = (t - m_pos[m_cur] + 24) % 24;
      m_pos[m_cur] = t;
      m_steps[m_cur] = (m_steps[m_cur] + adv > WIN) ? WIN : m_steps[m_cur] + adv;
      all = 1;
      for (int i = 0; i < 12; i++) all &= m_rev[i];
      if (m_steps[m_cur] == WIN) begin
        m_done = 1; m_winner = m_cur;
      end else if (all) begin
        for (int i = 0; i < 12; i++) m_rev[i] = 0;
        m_cur = 1 - m_cur;
      end
      low = 1;
    end else begin
      for (int i = 0; i < 12; i++) m_rev[i] = 0;
      m_cur = 1 - m_cur;
      low = 1 + SHOW;
    end
  endtask

  function automatic int choose(input bit greedy);
    int r, t, off, cands[$], good[$];
    t = m_target();
    for (int i = 0; i < 12; i++) if (!m_rev[i]) begin
      cands.push_back(i);
      if (m_card[i] == m_edge[t]) good.push_back(i);
    end
    r = greedy ? 50 : int'($urandom_range(0, 99));
    if (r < 8) return 12 + int'($urandom_range(0, 3));
    if (r < 14 && cands.size() < 12) begin
      off = $urandom_range(0, 11);
      for (int k = 0; k < 12; k++) if (m_rev[(off + k) % 12]) return (off + k) % 12;
    end
    if (good.size() > 0 && r < 80) return good[$urandom_range(0, good.size() - 1)];
    return cands[$urandom_range(0, cands.size() - 1)];
  endfunction

  task automatic check_state(input string tag);
    #1;
    check({tag, "_ready"}, pick_ready, (m_active && !m_done));
    check({tag, "_over"}, game_over, m_done);
    check({tag, "_pos0"}, pos_p0, m_pos[0]);
    check({tag, "_pos1"}, pos_p1, m_pos[1]);
    check({tag, "_cur"}, cur_player, m_cur);
    check({tag, "_mask"}, reveal_mask, m_mask());
    check({tag, "_queue"}, q.size(), 0);
    if (m_done) check({tag, "_winner"}, winner, m_winner);
  endtask

  // Issues one pick (called at a negedge while ready), optionally holding valid through busy cycles
  task automatic do_pick(input int idx);
    bit e, m, hold;
    int low, cnt;
    check_state("pre");
    model_pick(idx, e, m, low);
    q.push_back('{is_err: e, match: m});
    hold = $urandom_range(0, 1);
    pick_valid = 1'b1; pick_idx = 4'(idx);
    @(posedge clk); #1;
    if (!hold || e) pick_valid = 1'b0;
    else pick_idx = 4'($urandom_range(0, 15));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pick_ready || game_over) break;
      cnt++;
    end
    pick_valid = 1'b0;
    check("busy_cycles", cnt, low);
  endtask

  task automatic do_load(input bit directed, input bit with_pick);
    logic [95:0] eo;
    logic [47:0] co;
    for (int p = 0; p < 24; p++) begin
      m_edge[p] = directed ? p % 12 : int'($urandom_range(0, 11));
      eo[p*4 +: 4] = 4'(m_edge[p]);
    end
    for (int i = 0; i < 12; i++) begin
      m_card[i] = directed ? i : int'($urandom_range(0, 11));
      co[i*4 +: 4] = 4'(m_card[i]);
    end
    edge_order = eo; center_order = co; load = 1'b1;
    if (with_pick) begin
      pick_valid = 1'b1; pick_idx = 4'($urandom_range(0, 11));
    end
    @(posedge clk); #1;
    load = 1'b0; pick_valid = 1'b0;
    m_restart(1);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_restart(0);
    #1;
    check("rst_ready", pick_ready, 0);
    check("rst_result", result_valid, 0);
    check("rst_pos0", pos_p0, 0);
    check("rst_pos1", pos_p1, 12);
    check("rst_mask", reveal_mask, 0);
    check("rst_over", game_over, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic finish_game(input string tag);
    if (m_done) begin
      pick_valid = 1'b1;
      repeat (4) begin
        pick_idx = 4'($urandom_range(0, 11));
        @(negedge clk);
      end
      pick_valid = 1'b0;
      check_state(tag);
    end
  endtask

  // Scoreboard monitor: every pick_err / result_valid pulse consumes one expected response
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (pick_err || result_valid)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_response: err=%0b valid=%0b with nothing expected", pick_err, result_valid);
      end else begin
        e = q.pop_front();
        if (pick_err !== e.is_err || result_valid !== !e.is_err || (!e.is_err && result_match !== e.match)) begin
          fails++;
          $display("FAIL response: err=%0b valid=%0b match=%0b expected err=%0b match=%0b",
                   pick_err, result_valid, result_match, e.is_err, e.match);
        end
      end
    end
  end

  initial begin
    bit e, m;
    int low;
    #3;
    apply_reset();
    pick_valid = 1'b1; pick_idx = 4'd0;
    repeat (3) @(negedge clk);
    pick_valid = 1'b0;
    check_state("idle");

    do_load(1, 0);
    do_pick(1); do_pick(5); do_pick(12); do_pick(1); do_pick(1);
    check_state("directed");

    do_load(1, 0);
    for (int i = 1; i < 12; i++) do_pick(i);
    do_pick(0);
    check_state("jump");

    // Reset while a mismatched card is being shown
    do_load(1, 0);
    model_pick(5, e, m, low);
    q.push_back('{is_err: e, match: m});
    pick_valid = 1'b1; pick_idx = 4'd5;
    @(posedge clk); #1; pick_valid = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    apply_reset();
    check_state("after_rst");

    do_load(1, 0);
    for (int n = 0; n < 200 && !m_done; n++) do_pick(choose(1));
    check("greedy_win", m_done, 1);
    finish_game("greedy_done");

    for (int g = 0; g < 4; g++) begin
      do_load(0, 1);
      for (int n = 0; n < 400 && !m_done; n++) do_pick(choose(0));
      finish_game("random_done");
    end
    do_load(0, 1);
    check_state("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
